// File: rtl/vector_load_10_nir.sv
// vector_load_10_nir
//   Serial-to-parallel loader for the 10-element vector adders. Accepts one
//   (inA, inB) pair per enabled cycle, gathers 10 pairs in a collect buffer and
//   copies them into a separate output buffer on the edge that accepts the
//   10th pair. The output buffer is therefore stable for a whole collection
//   period (double buffering, no back-pressure).
//
// Ports
//   clk, reset        clock, async active-high reset
//   enable            clock enable; 0 holds every register, strobes included
//   clear             synchronous discard of the partial vector (beats inValid)
//   inValid, inA, inB streamed element pair
//   A0..A9, B0..B9    assembled vector (output buffer)
//   outReady          1-cycle strobe: new vector on A*/B*
//   earlyOutReady     1-cycle strobe: next accepted element completes a vector
//   fill              elements collected in the current partial vector, 0..9

// One element position: collect slot plus output-buffer slot.
module vector_load_10_nir_lane #(
  parameter int IN_WIDTH = 15,
  parameter bit LAST     = 1'b0   // last slot copies the live input on completion
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr,     // accept into this slot
  input  logic                cp,     // vector completes this edge
  input  logic [IN_WIDTH-1:0] in_a,
  input  logic [IN_WIDTH-1:0] in_b,
  output logic [IN_WIDTH-1:0] out_a,
  output logic [IN_WIDTH-1:0] out_b
);
  logic [IN_WIDTH-1:0] col_a, col_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_a <= '0;
      col_b <= '0;
      out_a <= '0;
      out_b <= '0;
    end else begin
      if (wr) begin
        col_a <= in_a;
        col_b <= in_b;
      end
      // The final element is not in the collect buffer yet on the completing
      // edge, so take it straight from the input.
      if (cp) begin
        out_a <= LAST ? in_a : col_a;
        out_b <= LAST ? in_b : col_b;
      end
    end
  end
endmodule

module vector_load_10_nir #(
  parameter int IN_WIDTH = 15,
  parameter int VEC_LEN  = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       clear,
  input  logic                       inValid,
  input  logic signed [IN_WIDTH-1:0] inA,
  input  logic signed [IN_WIDTH-1:0] inB,
  output logic signed [IN_WIDTH-1:0] A0, A1, A2, A3, A4, A5, A6, A7, A8, A9,
  output logic signed [IN_WIDTH-1:0] B0, B1, B2, B3, B4, B5, B6, B7, B8, B9,
  output logic                       outReady,
  output logic                       earlyOutReady,
  output logic [3:0]                 fill
);
  logic [VEC_LEN-1:0][IN_WIDTH-1:0] oa, ob;
  logic accept, last, complete;

  assign accept   = enable && inValid && !clear;
  assign last     = (fill == 4'(VEC_LEN - 1));
  assign complete = accept && last;

  for (genvar i = 0; i < VEC_LEN; i++) begin : g_lane
    vector_load_10_nir_lane #(
      .IN_WIDTH(IN_WIDTH),
      .LAST    (i == VEC_LEN - 1)
    ) u_lane (
      .clk  (clk),
      .reset(reset),
      .wr   (accept && (fill == 4'(i))),
      .cp   (complete),
      .in_a (inA),
      .in_b (inB),
      .out_a(oa[i]),
      .out_b(ob[i])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill          <= '0;
      outReady      <= 1'b0;
      earlyOutReady <= 1'b0;
    end else if (enable) begin
      // Strobes are single-cycle: anything other than the triggering accept
      // (idle, clear) drops them.
      outReady      <= complete;
      earlyOutReady <= accept && (fill == 4'(VEC_LEN - 2));
      if (clear)         fill <= '0;
      else if (complete) fill <= '0;
      else if (accept)   fill <= fill + 4'd1;
    end
  end

  assign A0 = oa[0]; assign A1 = oa[1]; assign A2 = oa[2]; assign A3 = oa[3];
  assign A4 = oa[4]; assign A5 = oa[5]; assign A6 = oa[6]; assign A7 = oa[7];
  assign A8 = oa[8]; assign A9 = oa[9];
  assign B0 = ob[0]; assign B1 = ob[1]; assign B2 = ob[2]; assign B3 = ob[3];
  assign B4 = ob[4]; assign B5 = ob[5]; assign B6 = ob[6]; assign B7 = ob[7];
  assign B8 = ob[8]; assign B9 = ob[9];
endmodule

// File: tb/tb_vector_load_10_nir.sv
module tb_vector_load_10_nir;
  localparam int W = 15;
  localparam int N = 10;
  localparam int VW = W * N;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0, clear = 1'b0, inValid = 1'b0;
  logic signed [W-1:0] inA = '0, inB = '0;
  logic signed [W-1:0] A0, A1, A2, A3, A4, A5, A6, A7, A8, A9;
  logic signed [W-1:0] B0, B1, B2, B3, B4, B5, B6, B7, B8, B9;
  logic outReady, earlyOutReady;
  logic [3:0] fill;

  vector_load_10_nir dut (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear), .inValid(inValid),
    .inA(inA), .inB(inB),
    .A0(A0), .A1(A1), .A2(A2), .A3(A3), .A4(A4), .A5(A5), .A6(A6), .A7(A7), .A8(A8), .A9(A9),
    .B0(B0), .B1(B1), .B2(B2), .B3(B3), .B4(B4), .B5(B5), .B6(B6), .B7(B7), .B8(B8), .B9(B9),
    .outReady(outReady), .earlyOutReady(earlyOutReady), .fill(fill)
  );

  always #5 clk = ~clk;

  wire [VW-1:0] dut_a = {A9, A8, A7, A6, A5, A4, A3, A2, A1, A0};
  wire [VW-1:0] dut_b = {B9, B8, B7, B6, B5, B5 ^ B5 ^ B4, B3, B2, B1, B0};

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Elements are kept as a plain list; a vector is emitted whenever the list
  // reaches ten entries.
  logic signed [W-1:0] col_a[$], col_b[$];
  logic [VW-1:0] cur_a, cur_b;        // what A*/B* should show
  logic [VW-1:0] exp_a[$], exp_b[$];  // scoreboard of completed vectors
  bit m_out, m_early;

  initial begin
    cur_a = '0; cur_b = '0; m_out = 0; m_early = 0;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        col_a.delete(); col_b.delete(); exp_a.delete(); exp_b.delete();
        cur_a = '0; cur_b = '0; m_out = 0; m_early = 0;
      end else if (enable) begin
        if (clear) begin
          col_a.delete(); col_b.delete();
          m_out = 0; m_early = 0;
        end else if (inValid) begin
          col_a.push_back(inA); col_b.push_back(inB);
          m_early = (col_a.size() == N - 1);
          m_out = 0;
          if (col_a.size() == N) begin
            for (int i = 0; i < N; i++) begin
              cur_a[i*W +: W] = col_a[i];
              cur_b[i*W +: W] = col_b[i];
            end
            exp_a.push_back(cur_a); exp_b.push_back(cur_b);
            col_a.delete(); col_b.delete();
            m_out = 1;
          end
        end else begin
          m_out = 0; m_early = 0;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  // Inputs change just after the rising edge, so at the falling edge both the
  // settled outputs and the enable for the next edge are visible. A vector is
  // consumed by the downstream adder when outReady and enable coincide.
  initial begin
    logic [VW-1:0] ea, eb;
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("fill", VW'(fill), VW'(col_a.size()));
        chk("outReady", VW'(outReady), VW'(m_out));
        chk("earlyOutReady", VW'(earlyOutReady), VW'(m_early));
        chk("bufA", dut_a, cur_a);
        chk("bufB", dut_b, cur_b);
        if (outReady && enable) begin
          if (exp_a.size() == 0) begin
            chk("spurious_vector", 1, 0);
          end else begin
            ea = exp_a.pop_front(); eb = exp_b.pop_front();
            chk("vecA", dut_a, ea);
            chk("vecB", dut_b, eb);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit en, input bit clr, input bit v, input int a, input int b);
    enable = en; clear = clr; inValid = v; inA = W'(a); inB = W'(b);
    @(posedge clk); #1;
  endtask

  task automatic areset_pulse();
    #2 reset = 1'b1;
    #1;
    chk("rst_fill", VW'(fill), '0);
    chk("rst_strobes", VW'({outReady, earlyOutReady}), '0);
    chk("rst_A", dut_a, '0);
    chk("rst_B", dut_b, '0);
    #1 reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int mn, mx;
    mn = -(1 <<< (W - 1));
    mx = (1 <<< (W - 1)) - 1;
    #12;
    chk("reset_fill", VW'(fill), '0);
    chk("reset_A", dut_a, '0);
    reset = 1'b0;
    @(posedge clk); #1;

    // back-to-back: two vectors, k = 0..19, A = k, B = -k
    for (int k = 0; k < 20; k++) cyc(1, 0, 1, k, -k);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);

    // gapped input
    for (int k = 0; k < 10; k++) begin
      cyc(1, 0, 1, 50 + k, -50 - k);
      cyc(1, 0, 0, 7, 7);
    end
    cyc(1, 0, 0, 0, 0);

    // clear mid-vector; the element presented with clear is dropped
    for (int k = 0; k < 5; k++) cyc(1, 0, 1, 200 + k, 300 + k);
    cyc(1, 1, 1, 999, 999);
    for (int k = 0; k < 10; k++) cyc(1, 0, 1, 100 + k, -(100 + k));
    // enable freeze while outReady is high
    cyc(0, 0, 1, 1, 1);
    cyc(0, 0, 1, 2, 2);
    cyc(0, 1, 1, 3, 3);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);

    // async reset mid-collection, then extreme values
    for (int k = 0; k < 7; k++) cyc(1, 0, 1, k + 1, k + 2);
    areset_pulse();
    for (int k = 0; k < 20; k++)
      cyc(1, 0, 1, (k % 2) ? mx : mn, (k % 2) ? mn : mx);
    cyc(1, 0, 0, 0, 0);

    // random traffic
    for (int n = 0; n < 2000; n++)
      cyc($urandom_range(0, 9) != 0, $urandom_range(0, 39) == 0,
          $urandom_range(0, 9) < 7, int'($urandom), int'($urandom));
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("scoreboard_drained", VW'(exp_a.size()), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
